cg_rvarch_svxx_ptw: RTL and testbench

- Hardware page-table walker for RISC-V Sv39 and Sv48, with Bare pass-through.
- Translation mode is selected at run time from satp.MODE.
- Sits between the TLB miss path and a read-only memory port.
- Adds over the previous walker: valid/ready handshakes on every interface, canonical-address, reserved-bit, A-bit and superpage-alignment fault detection with a cause code, page-level reporting, and walk abort.

---
 rtl/cg_rvarch_ptw_pkg.sv | 45 ++++
 rtl/cg_rvarch_pte_check.sv | 40 ++++
 rtl/cg_rvarch_svxx_ptw.sv | 237 +++++++++++++++++++++++
 tb/tb_cg_rvarch_svxx_ptw.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_rvarch_ptw_pkg.sv
// rtl/cg_rvarch_ptw_pkg.sv - shared types and constants for the Sv39/Sv48 page-table walker
package cg_rvarch_ptw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_RESP  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_BAD_MODE   = 3'd1,
        FC_NONCANON   = 3'd2,
        FC_INVALID    = 3'd3,
        FC_ACCESS     = 3'd4,
        FC_MISALIGNED = 3'd5,
        FC_DEPTH      = 3'd6
    } fault_cause_t;

    localparam logic [3:0] MODE_BARE = 4'd0;
    localparam logic [3:0] MODE_SV39 = 4'd8;
    localparam logic [3:0] MODE_SV48 = 4'd9;

    // PTE bit positions
    localparam int PTE_V        = 0;
    localparam int PTE_R        = 1;
    localparam int PTE_W        = 2;
    localparam int PTE_X        = 3;
    localparam int PTE_U        = 4;
    localparam int PTE_G        = 5;
    localparam int PTE_A        = 6;
    localparam int PTE_D        = 7;
    localparam int PTE_PPN_LSB  = 10;
    localparam int PTE_PPN_MSB  = 53;
    localparam int PTE_RSVD_LSB = 54;

    localparam int PPN_WIDTH     = 44;
    localparam int SATP_MODE_LSB = 60;
    localparam int PAGE_OFFSET   = 12;
    localparam int VPN_BITS      = 9;

endpackage

// File: rtl/cg_rvarch_pte_check.sv
// rtl/cg_rvarch_pte_check.sv - combinational PTE classification and fault cause
module cg_rvarch_pte_check
    import cg_rvarch_ptw_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] pte,
    input  logic [1:0]            level,
    output logic                  leaf,
    output logic                  fault,
    output logic [2:0]            cause
);

    logic [PPN_WIDTH-1:0] ppn;
    logic [PPN_WIDTH-1:0] align_mask;
    logic                 unused_bits;

    assign ppn         = pte[PTE_PPN_MSB:PTE_PPN_LSB];
    assign unused_bits = ^{pte[9:8], pte[PTE_D], pte[PTE_G], pte[PTE_U]};

    // Priority: malformed entry, then leaf checks, then depth exhaustion
    always_comb begin
        align_mask = ~({PPN_WIDTH{1'b1}} << (VPN_BITS * level));
        leaf       = pte[PTE_R] | pte[PTE_X];
        cause      = FC_NONE;
        if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]) || (|pte[DATA_WIDTH-1:PTE_RSVD_LSB])) begin
            cause = FC_INVALID;
        end else if (leaf) begin
            if (!pte[PTE_A]) begin
                cause = FC_ACCESS;
            end else if ((level != 2'd0) && (|(ppn & align_mask))) begin
                cause = FC_MISALIGNED;
            end
        end else if (level == 2'd0) begin
            cause = FC_DEPTH;
        end
        fault = (cause != FC_NONE);
    end

endmodule

// File: rtl/cg_rvarch_svxx_ptw.sv
// rtl/cg_rvarch_svxx_ptw.sv - Sv39/Sv48/Bare hardware page-table walker with abort
module cg_rvarch_svxx_ptw
    import cg_rvarch_ptw_pkg::*;
#(
    parameter int VADDR_WIDTH = 48,
    parameter int PADDR_WIDTH = 56,
    parameter int DATA_WIDTH  = 64,
    parameter int ATTR_WIDTH  = 11,
    parameter int MAX_LEVELS  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [DATA_WIDTH-1:0]  i_satp,
    input  logic                   i_walk_valid,
    output logic                   o_walk_ready,
    input  logic [VADDR_WIDTH-1:0] i_walk_vaddr,
    input  logic                   i_abort,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [PADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                   i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]  i_mem_rsp_data,
    output logic                   o_ptw_valid,
    input  logic                   i_ptw_ready,
    output logic [PADDR_WIDTH-1:0] o_ptw_paddr,
    output logic [ATTR_WIDTH-1:0]  o_ptw_pte_attr,
    output logic [1:0]             o_ptw_level,
    output logic                   o_ptw_fault,
    output logic [2:0]             o_ptw_fault_cause
);

    state_t                 state;
    logic [VADDR_WIDTH-1:0] vaddr_q;
    logic [DATA_WIDTH-1:0]  pte_q;
    logic [1:0]             level_q;

    logic [3:0]             req_mode;
    logic [PPN_WIDTH-1:0]   satp_ppn;
    logic                   mode_ok;
    logic [1:0]             start_level;
    logic                   start_canonical;
    logic                   chk_leaf;
    logic                   chk_fault;
    logic [2:0]             chk_cause;
    logic [PPN_WIDTH-1:0]   pte_ppn;
    logic [ATTR_WIDTH-1:0]  pte_attr;
    logic                   unused_satp;

    assign req_mode    = i_satp[SATP_MODE_LSB +: 4];
    assign satp_ppn    = i_satp[PPN_WIDTH-1:0];
    assign unused_satp = ^i_satp[SATP_MODE_LSB-1:PPN_WIDTH];
    assign pte_ppn     = pte_q[PTE_PPN_MSB:PTE_PPN_LSB];
    assign pte_attr    = {pte_q[DATA_WIDTH-1 -: 3], pte_q[PTE_D:PTE_V]};

    // Upper bits must replicate bit va_bits-1
    function automatic logic is_canonical(input logic [VADDR_WIDTH-1:0] va, input int va_bits);
        logic [VADDR_WIDTH-1:0] hi;
        logic [VADDR_WIDTH-1:0] ones;
        hi   = va >> (va_bits - 1);
        ones = {VADDR_WIDTH{1'b1}} >> (va_bits - 1);
        return (hi == '0) || (hi == ones);
    endfunction

    function automatic logic [PADDR_WIDTH-1:0] pte_addr(input logic [PPN_WIDTH-1:0] ppn,
                                                         input logic [VADDR_WIDTH-1:0] va,
                                                         input logic [1:0] lvl);
        logic [VPN_BITS-1:0] vpn;
        vpn = va[PAGE_OFFSET + VPN_BITS * lvl +: VPN_BITS];
        return PADDR_WIDTH'({ppn, vpn, 3'b000});
    endfunction

    // Superpages keep the low 12 + 9*level bits from the virtual address
    function automatic logic [PADDR_WIDTH-1:0] leaf_paddr(input logic [PPN_WIDTH-1:0] ppn,
                                                           input logic [VADDR_WIDTH-1:0] va,
                                                           input logic [1:0] lvl);
        logic [PADDR_WIDTH-1:0] base;
        logic [PADDR_WIDTH-1:0] off;
        logic [PADDR_WIDTH-1:0] mask;
        base = PADDR_WIDTH'({ppn, 12'h000});
        off  = PADDR_WIDTH'(va);
        mask = ~({PADDR_WIDTH{1'b1}} << (PAGE_OFFSET + VPN_BITS * lvl));
        return (base & ~mask) | (off & mask);
    endfunction

    // Decode the requested mode and its starting level at accept time
    always_comb begin
        mode_ok         = 1'b0;
        start_level     = 2'd2;
        start_canonical = 1'b0;
        if (req_mode == MODE_SV39) begin
            mode_ok         = 1'b1;
            start_level     = 2'd2;
            start_canonical = is_canonical(i_walk_vaddr, 39);
        end else if ((req_mode == MODE_SV48) && (MAX_LEVELS == 4)) begin
            mode_ok         = 1'b1;
            start_level     = 2'd3;
            start_canonical = is_canonical(i_walk_vaddr, 48);
        end
    end

    cg_rvarch_pte_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pte_check (
        .pte   (pte_q),
        .level (level_q),
        .leaf  (chk_leaf),
        .fault (chk_fault),
        .cause (chk_cause)
    );

    // Walk sequencer with registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state             <= S_IDLE;
            vaddr_q           <= '0;
            pte_q             <= '0;
            level_q           <= '0;
            o_walk_ready      <= 1'b1;
            o_mem_req_valid   <= 1'b0;
            o_mem_req_addr    <= '0;
            o_ptw_valid       <= 1'b0;
            o_ptw_paddr       <= '0;
            o_ptw_pte_attr    <= '0;
            o_ptw_level       <= '0;
            o_ptw_fault       <= 1'b0;
            o_ptw_fault_cause <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_walk_valid) begin
                        vaddr_q        <= i_walk_vaddr;
                        o_walk_ready   <= 1'b0;
                        o_ptw_pte_attr <= '0;
                        o_ptw_paddr    <= '0;
                        if (req_mode == MODE_BARE) begin
                            state             <= S_RESP;
                            o_ptw_valid       <= 1'b1;
                            o_ptw_paddr       <= PADDR_WIDTH'(i_walk_vaddr);
                            o_ptw_level       <= 2'd0;
                            o_ptw_fault       <= 1'b0;
                            o_ptw_fault_cause <= FC_NONE;
                        end else if (!mode_ok) begin
                            state             <= S_RESP;
                            o_ptw_valid       <= 1'b1;
                            o_ptw_level       <= 2'd0;
                            o_ptw_fault       <= 1'b1;
                            o_ptw_fault_cause <= FC_BAD_MODE;
                        end else if (!start_canonical) begin
                            state             <= S_RESP;
                            o_ptw_valid       <= 1'b1;
                            o_ptw_level       <= start_level;
                            o_ptw_fault       <= 1'b1;
                            o_ptw_fault_cause <= FC_NONCANON;
                        end else begin
                            state           <= S_REQ;
                            level_q         <= start_level;
                            o_mem_req_valid <= 1'b1;
                            o_mem_req_addr  <= pte_addr(satp_ppn, i_walk_vaddr, start_level);
                        end
                    end
                end
                S_REQ: begin
                    if (i_abort) begin
                        o_mem_req_valid <= 1'b0;
                        if (i_mem_req_ready) begin
                            state <= S_DRAIN;
                        end else begin
                            state        <= S_IDLE;
                            o_walk_ready <= 1'b1;
                        end
                    end else if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        if (i_mem_rsp_valid) begin
                            state        <= S_IDLE;
                            o_walk_ready <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (i_mem_rsp_valid) begin
                        pte_q <= i_mem_rsp_data;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (i_abort) begin
                        state        <= S_IDLE;
                        o_walk_ready <= 1'b1;
                    end else if (chk_fault) begin
                        state             <= S_RESP;
                        o_ptw_valid       <= 1'b1;
                        o_ptw_paddr       <= '0;
                        o_ptw_pte_attr    <= pte_attr;
                        o_ptw_level       <= level_q;
                        o_ptw_fault       <= 1'b1;
                        o_ptw_fault_cause <= chk_cause;
                    end else if (chk_leaf) begin
                        state             <= S_RESP;
                        o_ptw_valid       <= 1'b1;
                        o_ptw_paddr       <= leaf_paddr(pte_ppn, vaddr_q, level_q);
                        o_ptw_pte_attr    <= pte_attr;
                        o_ptw_level       <= level_q;
                        o_ptw_fault       <= 1'b0;
                        o_ptw_fault_cause <= FC_NONE;
                    end else begin
                        state           <= S_REQ;
                        level_q         <= level_q - 2'd1;
                        o_mem_req_valid <= 1'b1;
                        o_mem_req_addr  <= pte_addr(pte_ppn, vaddr_q, level_q - 2'd1);
                    end
                end
                S_RESP: begin
                    if (i_ptw_ready) begin
                        o_ptw_valid  <= 1'b0;
                        o_walk_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (i_mem_rsp_valid) begin
                        o_walk_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    o_walk_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cg_rvarch_svxx_ptw.sv
// tb/tb_cg_rvarch_svxx_ptw.sv - scoreboard bench for the page-table walker
module tb_cg_rvarch_svxx_ptw;

    localparam int VW = 48;
    localparam int PW = 56;
    localparam int DW = 64;
    localparam int AW = 11;

    localparam logic [63:0] SATP_SV39 = 64'h8000_0000_0008_0000;
    localparam logic [63:0] SATP_SV48 = 64'h9000_0000_0008_0000;
    localparam logic [63:0] SATP_BAD  = 64'h5000_0000_0008_0000;
    localparam logic [47:0] VA_MEGA   = 48'h0000_4020_1abc;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] satp;
    logic          walk_valid;
    logic          walk_ready;
    logic [VW-1:0] walk_vaddr;
    logic          abort;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [PW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          ptw_valid;
    logic          ptw_ready;
    logic [PW-1:0] ptw_paddr;
    logic [AW-1:0] ptw_attr;
    logic [1:0]    ptw_level;
    logic          ptw_fault;
    logic [2:0]    ptw_cause;

    typedef struct packed {
        logic [PW-1:0] paddr;
        logic [AW-1:0] attr;
        logic [1:0]    level;
        logic          fault;
        logic [2:0]    cause;
    } res_t;

    typedef struct {
        res_t r;
        int   lat;
        int   acc;
    } exp_t;

    typedef struct {
        logic [PW-1:0] addr;
        logic [DW-1:0] data;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_count = 0;
    int rsp_extra = 0;
    int ready_hold = 0;

    always #5 clk = ~clk;

    cg_rvarch_svxx_ptw dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_satp            (satp),
        .i_walk_valid      (walk_valid),
        .o_walk_ready      (walk_ready),
        .i_walk_vaddr      (walk_vaddr),
        .i_abort           (abort),
        .o_mem_req_valid   (mem_req_valid),
        .i_mem_req_ready   (mem_req_ready),
        .o_mem_req_addr    (mem_req_addr),
        .i_mem_rsp_valid   (mem_rsp_valid),
        .i_mem_rsp_data    (mem_rsp_data),
        .o_ptw_valid       (ptw_valid),
        .i_ptw_ready       (ptw_ready),
        .o_ptw_paddr       (ptw_paddr),
        .o_ptw_pte_attr    (ptw_attr),
        .o_ptw_level       (ptw_level),
        .o_ptw_fault       (ptw_fault),
        .o_ptw_fault_cause (ptw_cause)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic res_t mk(input logic [PW-1:0] p, input logic [AW-1:0] a,
                                input logic [1:0] l, input logic f, input logic [2:0] c);
        res_t r;
        r.paddr = p;
        r.attr  = a;
        r.level = l;
        r.fault = f;
        r.cause = c;
        return r;
    endfunction

    function automatic res_t cur_res();
        return {ptw_paddr, ptw_attr, ptw_level, ptw_fault, ptw_cause};
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic mem_push(input logic [PW-1:0] a, input logic [DW-1:0] d);
        mem_t m;
        m.addr = a;
        m.data = d;
        mem_q.push_back(m);
    endtask

    task automatic start_walk(input logic [63:0] s, input logic [47:0] va, input res_t r,
                              input int lat, input bit expect_result);
        exp_t e;
        int   n;
        n = 0;
        while (!walk_ready && n < 200) begin
            step();
            n++;
        end
        check("walk_ready_before_walk", 256'(walk_ready), 256'(1'b1));
        satp       = s;
        walk_vaddr = va;
        walk_valid = 1'b1;
        if (expect_result) begin
            e.r   = r;
            e.lat = lat;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        step();
        walk_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || ptw_valid) && n < 300) begin
            step();
            n++;
        end
        check("walk_completes", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_walk_ready"}, 256'(walk_ready), 256'(1'b1));
        check({tag, "_outputs_zero"}, 256'({mem_req_valid, mem_req_addr, ptw_valid, cur_res()}), 256'(0));
    endtask

    // Memory model: ready back-pressure, address scoreboard, delayed responses
    initial begin : mem_model
        mem_t          ent;
        logic          pend;
        int            wait_n;
        logic [DW-1:0] pdata;
        logic [PW-1:0] held_addr;
        logic          holding;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        pend      = 1'b0;
        wait_n    = 0;
        pdata     = '0;
        held_addr = '0;
        holding   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rsp_valid = 1'b0;
            if (pend) begin
                if (wait_n == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = pdata;
                    pend          = 1'b0;
                end else begin
                    wait_n--;
                end
            end
            if (mem_req_valid && ready_hold > 0) begin
                mem_req_ready = 1'b0;
                ready_hold--;
                if (holding) check("req_addr_stable", 256'(mem_req_addr), 256'(held_addr));
                holding   = 1'b1;
                held_addr = mem_req_addr;
            end else begin
                mem_req_ready = 1'b1;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (holding) check("req_addr_stable", 256'(mem_req_addr), 256'(held_addr));
                holding = 1'b0;
                req_count++;
                check("req_expected", 256'(mem_q.size() > 0), 256'(1'b1));
                if (mem_q.size() > 0) begin
                    ent = mem_q.pop_front();
                    check("req_addr", 256'(mem_req_addr), 256'(ent.addr));
                    pdata = ent.data;
                end else begin
                    pdata = '0;
                end
                pend   = 1'b1;
                wait_n = rsp_extra;
            end
        end
    end

    // Result monitor: latency, stability while stalled, scoreboard compare
    initial begin : monitor
        exp_t e;
        res_t held;
        res_t cur;
        logic holding;
        holding = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #3;
            if (ptw_valid) begin
                cur = cur_res();
                if (holding) begin
                    check("resp_stable", 256'(cur), 256'(held));
                end else begin
                    check("resp_expected", 256'(exp_q.size() > 0), 256'(1'b1));
                    if (exp_q.size() > 0 && exp_q[0].lat >= 0)
                        check("latency", 256'(cyc - exp_q[0].acc), 256'(exp_q[0].lat));
                end
                if (ptw_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("result", 256'(cur), 256'(e.r));
                    end
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = cur;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int rc;
        int n;
        satp       = '0;
        walk_valid = 1'b0;
        walk_vaddr = '0;
        abort      = 1'b0;
        ptw_ready  = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        rstn = 1'b1;
        step();

        // Sv39 megapage
        mem_push(56'h8000_0008, 64'h2000_0401);
        mem_push(56'h8000_1008, 64'h2008_00CF);
        start_walk(SATP_SV39, VA_MEGA, mk(56'h8020_1abc, 11'h0CF, 2'd1, 1'b0, 3'd0), 7, 1'b1);
        wait_done();

        // Misaligned megapage leaf
        mem_push(56'h8000_0008, 64'h2000_0401);
        mem_push(56'h8000_1008, 64'h2008_04CF);
        start_walk(SATP_SV39, VA_MEGA, mk(56'h0, 11'h0CF, 2'd1, 1'b1, 3'd5), 7, 1'b1);
        wait_done();

        // Non-canonical Sv39 address: no memory traffic
        rc = req_count;
        start_walk(SATP_SV39, 48'h0080_0000_0000, mk(56'h0, 11'h0, 2'd2, 1'b1, 3'd2), 1, 1'b1);
        wait_done();
        check("noncanon_no_mem", 256'(req_count - rc), 256'(0));

        // Bare pass-through and unsupported mode
        start_walk(64'h0, 48'h1234, mk(56'h1234, 11'h0, 2'd0, 1'b0, 3'd0), 1, 1'b1);
        wait_done();
        start_walk(SATP_BAD, VA_MEGA, mk(56'h0, 11'h0, 2'd0, 1'b1, 3'd1), 1, 1'b1);
        wait_done();

        // Invalid root PTE, then leaf without A at level 2
        mem_push(56'h8000_0008, 64'h0);
        start_walk(SATP_SV39, VA_MEGA, mk(56'h0, 11'h0, 2'd2, 1'b1, 3'd3), 4, 1'b1);
        wait_done();
        mem_push(56'h8000_0008, 64'h2000_000F);
        start_walk(SATP_SV39, VA_MEGA, mk(56'h0, 11'h00F, 2'd2, 1'b1, 3'd4), 4, 1'b1);
        wait_done();

        // Sv48 4K walk with result back-pressure
        rc = req_count;
        mem_push(56'h8000_0008, 64'h2000_0401);
        mem_push(56'h8000_1008, 64'h2000_0801);
        mem_push(56'h8000_2008, 64'h2000_0C01);
        mem_push(56'h8000_3018, 64'h048D_14C3);
        ptw_ready = 1'b0;
        start_walk(SATP_SV48, 48'h0080_4020_3abc, mk(56'h1234_5abc, 11'h0C3, 2'd0, 1'b0, 3'd0), 13, 1'b1);
        n = 0;
        while (!ptw_valid && n < 100) begin
            step();
            n++;
        end
        check("sv48_result_seen", 256'(ptw_valid), 256'(1'b1));
        repeat (5) step();
        ptw_ready = 1'b1;
        wait_done();
        check("sv48_req_count", 256'(req_count - rc), 256'(4));

        // Abort while waiting; response arrives three cycles later
        rc = req_count;
        rsp_extra = 3;
        mem_push(56'h8000_0008, 64'h2000_0401);
        start_walk(SATP_SV39, VA_MEGA, '0, 0, 1'b0);
        n = 0;
        while (req_count == rc && n < 50) begin
            step();
            n++;
        end
        check("abort_req_issued", 256'(req_count - rc), 256'(1));
        rsp_extra = 0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        step();
        check("abort_ready_low_at_rsp", 256'(walk_ready), 256'(1'b0));
        step();
        check("abort_ready_after_rsp", 256'(walk_ready), 256'(1'b1));
        mem_push(56'h8000_0008, 64'h2000_0401);
        mem_push(56'h8000_1008, 64'h2008_00CF);
        start_walk(SATP_SV39, VA_MEGA, mk(56'h8020_1abc, 11'h0CF, 2'd1, 1'b0, 3'd0), 7, 1'b1);
        wait_done();

        // Request back-pressure for four cycles
        ready_hold = 4;
        mem_push(56'h8000_0008, 64'h2000_0401);
        mem_push(56'h8000_1008, 64'h2008_00CF);
        start_walk(SATP_SV39, VA_MEGA, mk(56'h8020_1abc, 11'h0CF, 2'd1, 1'b0, 3'd0), 11, 1'b1);
        wait_done();

        // Reset asserted while waiting for a response
        rc = req_count;
        rsp_extra = 3;
        mem_push(56'h8000_0008, 64'h2000_0401);
        start_walk(SATP_SV39, VA_MEGA, '0, 0, 1'b0);
        rsp_extra = 0;
        check("reset_walk_req_issued", 256'(req_count - rc), 256'(1));
        step();
        rstn = 1'b0;
        #1;
        check_reset_outputs("midwalk_reset");
        step();
        step();
        rstn = 1'b1;
        repeat (4) step();
        start_walk(64'h0, 48'h0000_abcd_0123, mk(56'h0000_abcd_0123, 11'h0, 2'd0, 1'b0, 3'd0), 1, 1'b1);
        wait_done();

        repeat (3) step();
        check("mem_entries_consumed", 256'(mem_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
